// File: rtl/cdb_arbiter_pkg.sv
// cdb_pkg: types and constants shared by the CDB arbiter slice.
//   cdb_pkt_t   - one broadcast payload (tag, wdata, inst_id)
//   arb_mode_e  - arbitration mode encoding (round-robin / fixed priority)
//   wrap_inc    - modulo-n increment used for the round-robin pointer
package cdb_pkg;

    localparam int CDB_TAG_W     = 4;
    localparam int CDB_ROB_PTR_W = 4;
    localparam int CDB_DATA_W    = 32;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]     tag;
        logic [CDB_DATA_W-1:0]    wdata;
        logic [CDB_ROB_PTR_W-1:0] inst_id;
    } cdb_pkt_t;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer channels (exu_*) and broadcast ports (cdb_*).
//   master - producer/consumer side: drives exu_req/tag/wdata/inst_id,
//            observes exu_rdy and the cdb_* broadcast
//   slave  - arbiter side: the mirror image
// Channel i of a flattened vector lives at [i*W +: W].
interface cdb_arbiter_if #(
    parameter int NUM_EXU   = 4,
    parameter int NUM_CDB   = 1,
    parameter int TAG_W     = 4,
    parameter int ROB_PTR_W = 4
);
    logic [NUM_EXU-1:0]           exu_req;
    logic [NUM_EXU-1:0]           exu_rdy;
    logic [NUM_EXU*TAG_W-1:0]     exu_tag;
    logic [NUM_EXU*32-1:0]        exu_wdata;
    logic [NUM_EXU*ROB_PTR_W-1:0] exu_inst_id;

    logic [NUM_CDB-1:0]           cdb_wr;
    logic [NUM_CDB*TAG_W-1:0]     cdb_tag;
    logic [NUM_CDB*32-1:0]        cdb_wdata;
    logic [NUM_CDB*ROB_PTR_W-1:0] cdb_inst_id;

    modport master (
        output exu_req, exu_tag, exu_wdata, exu_inst_id,
        input  exu_rdy, cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id
    );

    modport slave (
        input  exu_req, exu_tag, exu_wdata, exu_inst_id,
        output exu_rdy, cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id
    );
endinterface

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// rr_multi_grant: combinational multi-port grant scan.
//   req       in  NUM_EXU          requesting channels
//   start     in  IDX_W            first channel examined (wraps modulo NUM_EXU)
//   grant     out NUM_EXU          one-hot-per-channel grant, at most NUM_CDB bits set
//   port_idx  out NUM_CDB x IDX_W  channel feeding each port (k-th found -> port k)
//   port_vld  out NUM_CDB          port carries a grant this cycle
//   last_idx  out IDX_W            last channel granted in scan order
//   any_grant out 1                at least one grant
module rr_multi_grant #(
    parameter int NUM_EXU = 4,
    parameter int NUM_CDB = 1,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_EXU-1:0]            req,
    input  logic [IDX_W-1:0]              start,
    output logic [NUM_EXU-1:0]            grant,
    output logic [NUM_CDB-1:0][IDX_W-1:0] port_idx,
    output logic [NUM_CDB-1:0]            port_vld,
    output logic [IDX_W-1:0]              last_idx,
    output logic                          any_grant
);

    int               pos;
    int               cnt;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant    = '0;
        port_idx = '0;
        port_vld = '0;
        last_idx = '0;
        pos      = 0;
        cnt      = 0;
        idx      = '0;
        for (int o = 0; o < NUM_EXU; o++) begin
            pos = int'(start) + o;
            if (pos >= NUM_EXU) pos = pos - NUM_EXU;
            idx = IDX_W'(pos);
            if (req[idx] && cnt < NUM_CDB) begin
                grant[idx] = 1'b1;
                last_idx   = idx;
                // Constant port index keeps the write free of a runtime-sized select.
                for (int p = 0; p < NUM_CDB; p++) begin
                    if (p == cnt) begin
                        port_idx[p] = idx;
                        port_vld[p] = 1'b1;
                    end
                end
                cnt = cnt + 1;
            end
        end
    end

    assign any_grant = |grant;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges NUM_EXU execution-unit result channels onto NUM_CDB
// registered broadcast ports per cycle.
//   clk    in  rising-edge clock
//   rst    in  synchronous active-high reset (dominates flush)
//   flush  in  squash: blocks grants and drops the broadcast at this edge
//   bus    slave view of cdb_arbiter_if (exu_* handshake in, cdb_* out)
// ARB_MODE 0 = round-robin from rr_ptr, 1 = fixed priority from channel 0.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_EXU   = 4,
    parameter int NUM_CDB   = 1,
    parameter int TAG_W     = 4,
    parameter int ROB_DEPTH = 16,
    parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
    parameter int ARB_MODE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_EXU > 1) ? $clog2(NUM_EXU) : 1;
    localparam bit FIXED = (ARB_MODE == int'(ARB_FIXED));

    if (NUM_EXU < 2 || NUM_CDB < 1 || NUM_CDB > NUM_EXU ||
        TAG_W != CDB_TAG_W || ROB_PTR_W != CDB_ROB_PTR_W ||
        ARB_MODE < 0 || ARB_MODE > 1) begin : g_param_err
        $error("cdb_arbiter: illegal parameter combination");
    end

    logic [IDX_W-1:0]              rr_ptr;
    logic [IDX_W-1:0]              scan_start;
    logic [NUM_EXU-1:0]            grant;
    logic [NUM_CDB-1:0][IDX_W-1:0] port_idx;
    logic [NUM_CDB-1:0]            port_vld;
    logic [IDX_W-1:0]              last_idx;
    logic                          any_grant;

    cdb_pkt_t                      ch_pkt [NUM_EXU];
    cdb_pkt_t [NUM_CDB-1:0]        pkt_d;
    cdb_pkt_t [NUM_CDB-1:0]        pkt_q;
    logic [NUM_CDB-1:0]            wr_q;

    assign scan_start = FIXED ? '0 : rr_ptr;

    rr_multi_grant #(
        .NUM_EXU (NUM_EXU),
        .NUM_CDB (NUM_CDB),
        .IDX_W   (IDX_W)
    ) u_grant (
        .req       (bus.exu_req),
        .start     (scan_start),
        .grant     (grant),
        .port_idx  (port_idx),
        .port_vld  (port_vld),
        .last_idx  (last_idx),
        .any_grant (any_grant)
    );

    assign bus.exu_rdy = (rst || flush) ? '0 : grant;

    for (genvar i = 0; i < NUM_EXU; i++) begin : g_ch
        assign ch_pkt[i] = '{tag:     bus.exu_tag[i*TAG_W +: TAG_W],
                             wdata:   bus.exu_wdata[i*32 +: 32],
                             inst_id: bus.exu_inst_id[i*ROB_PTR_W +: ROB_PTR_W]};
    end

    always_comb begin
        pkt_d = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
            pkt_d[p] = ch_pkt[port_idx[p]];
        end
    end

    // Payload registers only load on a valid port so idle ports keep their
    // last broadcast; flush clears the valid bits but leaves payload alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            pkt_q  <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            wr_q <= '0;
        end else begin
            wr_q <= port_vld;
            for (int p = 0; p < NUM_CDB; p++) begin
                if (port_vld[p]) pkt_q[p] <= pkt_d[p];
            end
            if (!FIXED && any_grant) begin
                rr_ptr <= IDX_W'(wrap_inc(int'(last_idx), NUM_EXU));
            end
        end
    end

    assign bus.cdb_wr = wr_q;

    for (genvar p = 0; p < NUM_CDB; p++) begin : g_port
        assign bus.cdb_tag[p*TAG_W +: TAG_W]             = pkt_q[p].tag;
        assign bus.cdb_wdata[p*32 +: 32]                 = pkt_q[p].wdata;
        assign bus.cdb_inst_id[p*ROB_PTR_W +: ROB_PTR_W] = pkt_q[p].inst_id;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   req;
    logic [15:0]  tag_v;
    logic [127:0] wdata_v;
    logic [15:0]  id_v;

    logic [3:0]   exp1;
    logic [3:0]   exp2;
    logic [3:0]   exp_tag;
    logic [31:0]  exp_wd;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_EXU(4), .NUM_CDB(1), .TAG_W(4), .ROB_PTR_W(4)) if_rr1 ();
    cdb_arbiter_if #(.NUM_EXU(4), .NUM_CDB(1), .TAG_W(4), .ROB_PTR_W(4)) if_fx1 ();
    cdb_arbiter_if #(.NUM_EXU(4), .NUM_CDB(2), .TAG_W(4), .ROB_PTR_W(4)) if_rr2 ();

    assign if_rr1.exu_req = req;   assign if_rr1.exu_tag = tag_v;
    assign if_rr1.exu_wdata = wdata_v; assign if_rr1.exu_inst_id = id_v;
    assign if_fx1.exu_req = req;   assign if_fx1.exu_tag = tag_v;
    assign if_fx1.exu_wdata = wdata_v; assign if_fx1.exu_inst_id = id_v;
    assign if_rr2.exu_req = req;   assign if_rr2.exu_tag = tag_v;
    assign if_rr2.exu_wdata = wdata_v; assign if_rr2.exu_inst_id = id_v;

    cdb_arbiter #(.NUM_EXU(4), .NUM_CDB(1), .TAG_W(4), .ROB_DEPTH(16), .ARB_MODE(0))
        u_rr1 (.clk(clk), .rst(rst), .flush(flush), .bus(if_rr1));
    cdb_arbiter #(.NUM_EXU(4), .NUM_CDB(1), .TAG_W(4), .ROB_DEPTH(16), .ARB_MODE(1))
        u_fx1 (.clk(clk), .rst(rst), .flush(flush), .bus(if_fx1));
    cdb_arbiter #(.NUM_EXU(4), .NUM_CDB(2), .TAG_W(4), .ROB_DEPTH(16), .ARB_MODE(0))
        u_rr2 (.clk(clk), .rst(rst), .flush(flush), .bus(if_rr2));

    // channel i: tag 8+i, wdata A000_000i, inst_id 4+i
    task automatic set_defaults();
        tag_v   = {4'hB, 4'hA, 4'h9, 4'h8};
        wdata_v = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        id_v    = {4'd7, 4'd6, 4'd5, 4'd4};
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req = 4'b0000;
        repeat (2) begin
            #1;
            vectors++; if (if_rr1.exu_rdy !== 4'b0000) begin miscompares++; $display("FAIL rst_rdy_rr1: got %b want 0000", if_rr1.exu_rdy); end
            vectors++; if (if_rr2.exu_rdy !== 4'b0000) begin miscompares++; $display("FAIL rst_rdy_rr2: got %b want 0000", if_rr2.exu_rdy); end
            @(posedge clk); #1;
            vectors++; if (if_rr1.cdb_wr !== 1'b0) begin miscompares++; $display("FAIL rst_wr_rr1: got %b want 0", if_rr1.cdb_wr); end
            vectors++; if (if_fx1.cdb_wr !== 1'b0) begin miscompares++; $display("FAIL rst_wr_fx1: got %b want 0", if_fx1.cdb_wr); end
            vectors++; if (if_rr2.cdb_wr !== 2'b00) begin miscompares++; $display("FAIL rst_wr_rr2: got %b want 00", if_rr2.cdb_wr); end
            vectors++; if (if_rr1.cdb_tag !== 4'h0 || if_rr1.cdb_wdata !== 32'h0 || if_rr1.cdb_inst_id !== 4'h0) begin
                miscompares++; $display("FAIL rst_data_rr1: got %h/%h/%h want 0/0/0", if_rr1.cdb_tag, if_rr1.cdb_wdata, if_rr1.cdb_inst_id); end
            vectors++; if (if_rr2.cdb_wdata !== 64'h0) begin miscompares++; $display("FAIL rst_data_rr2: got %h want 0", if_rr2.cdb_wdata); end
        end
        rst = 1'b0; #1;
        vectors++; if (if_fx1.exu_rdy !== 4'b0000) begin miscompares++; $display("FAIL idle_rdy_fx1: got %b want 0000", if_fx1.exu_rdy); end
        @(posedge clk); #1;
        vectors++; if (if_rr1.cdb_wr !== 1'b0) begin miscompares++; $display("FAIL idle_wr_rr1: got %b want 0", if_rr1.cdb_wr); end
    endtask

    task automatic test_rr_fairness();
        for (int c = 0; c < 8; c++) begin
            req = 4'b1111; #1;
            exp1 = 4'b0001 << (c % 4);
            exp2 = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            vectors++; if (if_rr1.exu_rdy !== exp1) begin miscompares++; $display("FAIL rr_rdy_rr1[%0d]: got %b want %b", c, if_rr1.exu_rdy, exp1); end
            vectors++; if (if_fx1.exu_rdy !== 4'b0001) begin miscompares++; $display("FAIL fixed_rdy_fx1[%0d]: got %b want 0001", c, if_fx1.exu_rdy); end
            vectors++; if (if_rr2.exu_rdy !== exp2) begin miscompares++; $display("FAIL rr_rdy_rr2[%0d]: got %b want %b", c, if_rr2.exu_rdy, exp2); end
            @(posedge clk); #1;
            exp_tag = 4'(8 + (c % 4));
            vectors++; if (if_rr1.cdb_wr !== 1'b1 || if_rr1.cdb_tag !== exp_tag) begin
                miscompares++; $display("FAIL rr_cdb_rr1[%0d]: got wr=%b tag=%h want wr=1 tag=%h", c, if_rr1.cdb_wr, if_rr1.cdb_tag, exp_tag); end
            vectors++; if (if_fx1.cdb_wr !== 1'b1 || if_fx1.cdb_tag !== 4'h8) begin
                miscompares++; $display("FAIL fixed_cdb_fx1[%0d]: got wr=%b tag=%h want wr=1 tag=8", c, if_fx1.cdb_wr, if_fx1.cdb_tag); end
            vectors++; if (if_rr2.cdb_wr !== 2'b11 || if_rr2.cdb_tag !== ((c % 2 == 0) ? 8'h98 : 8'hBA)) begin
                miscompares++; $display("FAIL rr_cdb_rr2[%0d]: got wr=%b tag=%h", c, if_rr2.cdb_wr, if_rr2.cdb_tag); end
        end
    endtask

    task automatic test_single_producer();
        set_defaults();
        tag_v[11:8] = 4'h5; wdata_v[95:64] = 32'hDEAD_BEEF; id_v[11:8] = 4'd7;
        req = 4'b0100; #1;
        vectors++; if (if_rr1.exu_rdy !== 4'b0100) begin miscompares++; $display("FAIL sp_rdy_rr1: got %b want 0100", if_rr1.exu_rdy); end
        vectors++; if (if_fx1.exu_rdy !== 4'b0100) begin miscompares++; $display("FAIL sp_rdy_fx1: got %b want 0100", if_fx1.exu_rdy); end
        vectors++; if (if_rr2.exu_rdy !== 4'b0100) begin miscompares++; $display("FAIL sp_rdy_rr2: got %b want 0100", if_rr2.exu_rdy); end
        @(posedge clk); #1;
        vectors++; if (if_rr1.cdb_wr !== 1'b1 || if_rr1.cdb_tag !== 4'h5 || if_rr1.cdb_wdata !== 32'hDEAD_BEEF || if_rr1.cdb_inst_id !== 4'd7) begin
            miscompares++; $display("FAIL sp_cdb_rr1: got %b/%h/%h/%h want 1/5/deadbeef/7", if_rr1.cdb_wr, if_rr1.cdb_tag, if_rr1.cdb_wdata, if_rr1.cdb_inst_id); end
        vectors++; if (if_rr2.cdb_wr !== 2'b01 || if_rr2.cdb_tag[3:0] !== 4'h5 || if_rr2.cdb_wdata[31:0] !== 32'hDEAD_BEEF || if_rr2.cdb_inst_id[3:0] !== 4'd7) begin
            miscompares++; $display("FAIL sp_cdb_rr2: got %b/%h/%h/%h want 01/5/deadbeef/7", if_rr2.cdb_wr, if_rr2.cdb_tag, if_rr2.cdb_wdata, if_rr2.cdb_inst_id); end
    endtask

    // rr_ptr is 3 on both RR instances after the single-producer grant of ch2
    task automatic test_dual_port();
        set_defaults();
        req = 4'b1011; #1;
        vectors++; if (if_rr2.exu_rdy !== 4'b1001) begin miscompares++; $display("FAIL dp_rdy_rr2: got %b want 1001", if_rr2.exu_rdy); end
        vectors++; if (if_rr1.exu_rdy !== 4'b1000) begin miscompares++; $display("FAIL dp_ptr3_rr1: got %b want 1000", if_rr1.exu_rdy); end
        vectors++; if (if_fx1.exu_rdy !== 4'b0001) begin miscompares++; $display("FAIL dp_rdy_fx1: got %b want 0001", if_fx1.exu_rdy); end
        @(posedge clk); #1;
        vectors++; if (if_rr2.cdb_wr !== 2'b11 || if_rr2.cdb_tag !== 8'h8B || if_rr2.cdb_wdata !== 64'hA000_0000_A000_0003 || if_rr2.cdb_inst_id !== 8'h47) begin
            miscompares++; $display("FAIL dp_cdb_rr2: got %b/%h/%h/%h want 11/8b/a0000000a0000003/47", if_rr2.cdb_wr, if_rr2.cdb_tag, if_rr2.cdb_wdata, if_rr2.cdb_inst_id); end
        req = 4'b0010; #1;
        vectors++; if (if_rr2.exu_rdy !== 4'b0010) begin miscompares++; $display("FAIL dp2_rdy_rr2: got %b want 0010", if_rr2.exu_rdy); end
        vectors++; if (if_rr1.exu_rdy !== 4'b0010) begin miscompares++; $display("FAIL dp2_rdy_rr1: got %b want 0010", if_rr1.exu_rdy); end
        @(posedge clk); #1;
        vectors++; if (if_rr2.cdb_wr !== 2'b01 || if_rr2.cdb_tag[3:0] !== 4'h9 || if_rr2.cdb_wdata[31:0] !== 32'hA000_0001 || if_rr2.cdb_inst_id[3:0] !== 4'd5) begin
            miscompares++; $display("FAIL dp2_cdb_rr2: got %b/%h/%h/%h want 01/9/a0000001/5", if_rr2.cdb_wr, if_rr2.cdb_tag, if_rr2.cdb_wdata, if_rr2.cdb_inst_id); end
        vectors++; if (if_rr2.cdb_wdata[63:32] !== 32'hA000_0000) begin
            miscompares++; $display("FAIL dp2_hold_rr2: got %h want a0000000", if_rr2.cdb_wdata[63:32]); end
    endtask

    // entry: rr_ptr = 2 on both RR instances
    task automatic test_flush();
        req = 4'b0010; flush = 1'b0; #1;
        vectors++; if (if_rr1.exu_rdy !== 4'b0010) begin miscompares++; $display("FAIL fl_t_rdy_rr1: got %b want 0010", if_rr1.exu_rdy); end
        @(posedge clk); #1;
        req = 4'b1111; flush = 1'b1; #1;
        vectors++; if (if_rr1.exu_rdy !== 4'b0000) begin miscompares++; $display("FAIL fl_rdy_rr1: got %b want 0000", if_rr1.exu_rdy); end
        vectors++; if (if_fx1.exu_rdy !== 4'b0000) begin miscompares++; $display("FAIL fl_rdy_fx1: got %b want 0000", if_fx1.exu_rdy); end
        vectors++; if (if_rr2.exu_rdy !== 4'b0000) begin miscompares++; $display("FAIL fl_rdy_rr2: got %b want 0000", if_rr2.exu_rdy); end
        @(posedge clk); #1;
        vectors++; if (if_rr1.cdb_wr !== 1'b0) begin miscompares++; $display("FAIL fl_wr_rr1: got %b want 0", if_rr1.cdb_wr); end
        vectors++; if (if_fx1.cdb_wr !== 1'b0) begin miscompares++; $display("FAIL fl_wr_fx1: got %b want 0", if_fx1.cdb_wr); end
        vectors++; if (if_rr2.cdb_wr !== 2'b00) begin miscompares++; $display("FAIL fl_wr_rr2: got %b want 00", if_rr2.cdb_wr); end
        flush = 1'b0; #1;
        vectors++; if (if_rr1.exu_rdy !== 4'b0100) begin miscompares++; $display("FAIL fl_ptr_rr1: got %b want 0100", if_rr1.exu_rdy); end
        vectors++; if (if_rr2.exu_rdy !== 4'b1100) begin miscompares++; $display("FAIL fl_ptr_rr2: got %b want 1100", if_rr2.exu_rdy); end
        @(posedge clk); #1;
        vectors++; if (if_rr1.cdb_wr !== 1'b1 || if_rr1.cdb_tag !== 4'hA) begin
            miscompares++; $display("FAIL fl_post_rr1: got wr=%b tag=%h want wr=1 tag=a", if_rr1.cdb_wr, if_rr1.cdb_tag); end
    endtask

    // entry: rr1 rr_ptr = 3, rr2 rr_ptr = 0
    task automatic test_reset_mid();
        req = 4'b1111; #1;
        vectors++; if (if_rr1.exu_rdy !== 4'b1000) begin miscompares++; $display("FAIL rm_a_rdy_rr1: got %b want 1000", if_rr1.exu_rdy); end
        @(posedge clk); #1;
        vectors++; if (if_rr1.exu_rdy !== 4'b0001) begin miscompares++; $display("FAIL rm_b_rdy_rr1: got %b want 0001", if_rr1.exu_rdy); end
        @(posedge clk); #1;
        rst = 1'b1; flush = 1'b1; #1;
        vectors++; if (if_rr1.exu_rdy !== 4'b0000) begin miscompares++; $display("FAIL rm_rdy_rr1: got %b want 0000", if_rr1.exu_rdy); end
        vectors++; if (if_rr2.exu_rdy !== 4'b0000) begin miscompares++; $display("FAIL rm_rdy_rr2: got %b want 0000", if_rr2.exu_rdy); end
        @(posedge clk); #1;
        vectors++; if (if_rr1.cdb_wr !== 1'b0 || if_rr1.cdb_tag !== 4'h0 || if_rr1.cdb_wdata !== 32'h0 || if_rr1.cdb_inst_id !== 4'h0) begin
            miscompares++; $display("FAIL rm_cdb_rr1: got %b/%h/%h/%h want 0/0/0/0", if_rr1.cdb_wr, if_rr1.cdb_tag, if_rr1.cdb_wdata, if_rr1.cdb_inst_id); end
        vectors++; if (if_rr2.cdb_wr !== 2'b00) begin miscompares++; $display("FAIL rm_wr_rr2: got %b want 00", if_rr2.cdb_wr); end
        rst = 1'b0; flush = 1'b0; #1;
        vectors++; if (if_rr1.exu_rdy !== 4'b0001) begin miscompares++; $display("FAIL rm_restart_rr1: got %b want 0001", if_rr1.exu_rdy); end
        vectors++; if (if_rr2.exu_rdy !== 4'b0011) begin miscompares++; $display("FAIL rm_restart_rr2: got %b want 0011", if_rr2.exu_rdy); end
        @(posedge clk); #1;
        exp_wd = 32'hA000_0000;
        vectors++; if (if_rr1.cdb_wr !== 1'b1 || if_rr1.cdb_wdata !== exp_wd) begin
            miscompares++; $display("FAIL rm_cdb2_rr1: got wr=%b wdata=%h want wr=1 wdata=%h", if_rr1.cdb_wr, if_rr1.cdb_wdata, exp_wd); end
        #1;
        vectors++; if (if_rr1.exu_rdy !== 4'b0010) begin miscompares++; $display("FAIL rm_next_rr1: got %b want 0010", if_rr1.exu_rdy); end
        req = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (if_rr2.cdb_wr !== 2'b00) begin miscompares++; $display("FAIL idle_end_rr2: got %b want 00", if_rr2.cdb_wr); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req = 4'b0000;
        set_defaults();
        test_reset();
        test_rr_fairness();
        test_single_producer();
        test_dual_port();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
